prm_edge_mask_accum: RTL and testbench
======================================

# prm_edge_mask_accum

Downstream collector for the PRM obstacle-check bank. Streams 15-bit obstacle voxel codes from the scene loader into the bank of combinational `prm_oblgc_chk*` checkers, one code per cycle. It then OR-accumulates the per-edge `edge_mask` results into a blocked-edge bitmap. When a frame completes, the graph-search engine reads the bitmap word by word.

## Interface
Parameters:
- N_EDGE, 1024, number of roadmap edges; equals the number of checker instances; multiple of WORD_W.
- WORD_W, 32, readout word width.
- CODE_W, 15, obstacle code width; the code maps onto checker inputs A (bit 0) through O (bit 14).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a new frame.
- obs_valid  in  1  obstacle code valid.
- obs_ready  out  1  block accepts a code this cycle.
- obs_code  in  CODE_W  obstacle voxel code.
- obs_last  in  1  marks the final code of the frame; qualified by the handshake.
- chk_code  out  CODE_W  registered code driven to every checker instance.
- chk_mask  in  N_EDGE  concatenated `edge_mask` outputs; bit e comes from edge e's checker.
- busy  out  1  frame in progress.
- done  out  1  bitmap final; held high until the next start.
- rd_addr  in  $clog2(N_EDGE/WORD_W)  readout word index.
- rd_data  out  WORD_W  bitmap bits [rd_addr*WORD_W +: WORD_W], registered.
- obs_cnt  out  16  obstacles accepted this frame; present only with PRM_OBS_CNT_EN.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start moves to ACCUM and clears the bitmap and the stage-1 valid bit in the same cycle.
- ACCUM:
  - obs_ready = 1.
  - A transfer occurs when obs_valid && obs_ready. On a transfer, chk_code <= obs_code, s1_valid <= 1, s1_last <= obs_last. With no transfer, s1_valid <= 0.
  - Stage 1: when s1_valid is set, bitmap <= bitmap | chk_mask. chk_mask is combinational on chk_code.
  - A transfer with obs_last set moves to DRAIN.
- DRAIN:
  - obs_ready = 0.
  - The final stage-1 OR completes, then the state moves to DONE.
- DONE:
  - done = 1.
  - The bitmap is frozen.
  - start moves to ACCUM with the same clearing as from IDLE.
- start is ignored in ACCUM and DRAIN.
- obs_code is don't-care when obs_valid is low.
- A bitmap bit set to 1 means the edge is blocked.
- rd_data is valid in any state; reads before DONE return partial results.
- An out-of-range rd_addr returns 0.

## Timing
- Reset values:
  - State is IDLE.
  - obs_ready, busy and done are 0.
  - chk_code is 0.
  - Bitmap, rd_data and obs_cnt are all 0.
- busy = 1 in ACCUM and DRAIN.
- A code accepted at cycle t is reflected in the bitmap at t+2 (edge t+1 registers chk_code, edge t+2 ORs).
- done rises 2 cycles after the obs_last transfer.
- Back-to-back transfers are sustained at 1 code per cycle.
- Gaps (obs_valid low) insert bubbles and do not change results.
- rd_data latency: rd_data reflects rd_addr 1 cycle after it is sampled.
- Simultaneous start and read in DONE: rd_data shows the pre-clear bitmap for that cycle only.
- An empty frame is not supported: every frame ends with an obs_last transfer.
- Asynchronous reset mid-frame aborts the frame and returns all outputs to their reset values.

## Configuration
- PRM_OBS_CNT_EN: when defined, obs_cnt is present.
  - Cleared on start.
  - Incremented on each transfer.
  - Saturates at 16'hFFFF.
  - Frozen in DONE.
- Undefined: the port and the counter are absent. Bitmap behaviour is identical.

## Structure
- Shared package `prm_pkg` holds:
  - the state enum (IDLE/ACCUM/DRAIN/DONE);
  - CODE_W, N_EDGE and WORD_W defaults;
  - the function mapping a code to the checker letter order.
- Sub-module `prm_mask_bitmap` owns the N_EDGE flop array, clear, OR-merge and the registered word-read mux.
- The checker bank is instantiated outside this block. chk_code and chk_mask are wired at the top level.

## Test plan
- Reset then idle: rd_data = 0 for all addresses; done = 0; obs_ready = 0.
- Single-code frame: start, then code 15'h4000 with obs_last. Expected response:
  - done is asserted 2 cycles after acceptance.
  - The bitmap equals the model checker's mask for 15'h4000.
  - obs_cnt = 1.
- Streaming frame: 100 random back-to-back codes, with obs_valid randomly gapped. Expected: the bitmap equals the OR of the model masks; gap patterns do not change the result.
- Re-frame:
  - Pulse start in DONE after a frame left word 3 = 32'hFFFF_FFFF.
  - The next frame uses code 0 only, whose mask is all-zero in the model.
  - Expected: word 3 reads 0.
- start pulsed during ACCUM is ignored: the result equals the same frame without the pulse.
- Reset asserted mid-frame after 10 codes: outputs are 0 immediately; a fresh frame of 1 code gives the correct bitmap.

Source files
------------

// File: rtl/prm_pkg.sv
// Shared definitions for the PRM obstacle-check collector: FSM states,
// default geometry and the code-to-checker letter mapping.
package prm_pkg;

    localparam int PRM_CODE_W = 15;
    localparam int PRM_N_EDGE = 1024;
    localparam int PRM_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } prm_state_t;

    // Checker inputs are lettered A..O; letter A takes code bit 0, O takes bit 14.
    function automatic logic [PRM_CODE_W-1:0] code_to_chk(input logic [PRM_CODE_W-1:0] code);
        logic [PRM_CODE_W-1:0] letters;
        letters = '0;
        for (int unsigned i = 0; i < PRM_CODE_W; i++) begin
            letters[i] = code[i];
        end
        return letters;
    endfunction

endpackage

// File: rtl/prm_mask_bitmap.sv
// Blocked-edge bitmap: N_EDGE flops with synchronous clear, OR-merge of the
// checker bank mask, and a registered word-read mux (out-of-range reads give 0).
module prm_mask_bitmap #(
    parameter int N_EDGE = 1024,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              merge,
    input  logic [N_EDGE-1:0] mask,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int unsigned N_WORDS = N_EDGE / WORD_W;
    localparam int unsigned N_SLOTS = 1 << ADDR_W;

    logic [N_EDGE-1:0] bitmap;
    logic [WORD_W-1:0] words [N_SLOTS];

    // Clear on frame start, otherwise accumulate blocked edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
        end else if (clr) begin
            bitmap <= '0;
        end else if (merge) begin
            bitmap <= bitmap | mask;
        end
    end

    // Word view of the bitmap; slots beyond the last real word read as zero
    always_comb begin
        for (int unsigned w = 0; w < N_SLOTS; w++) begin
            words[w] = '0;
            if (w < N_WORDS) begin
                words[w] = bitmap[((w < N_WORDS) ? w : 0) * WORD_W +: WORD_W];
            end
        end
    end

    // Registered readout, one cycle after the address is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= words[rd_addr];
        end
    end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Collector for the PRM obstacle-check bank: streams obstacle codes to the
// external checker bank and OR-accumulates their edge masks into a bitmap.
// Optional obstacle counter port obs_cnt is built when PRM_OBS_CNT_EN is defined.
module prm_edge_mask_accum
    import prm_pkg::*;
#(
    parameter int N_EDGE = PRM_N_EDGE,
    parameter int WORD_W = PRM_WORD_W,
    parameter int CODE_W = PRM_CODE_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                obs_valid,
    output logic                                obs_ready,
    input  logic [CODE_W-1:0]                   obs_code,
    input  logic                                obs_last,
    output logic [CODE_W-1:0]                   chk_code,
    input  logic [N_EDGE-1:0]                   chk_mask,
    output logic                                busy,
    output logic                                done,
    input  logic [$clog2(N_EDGE/WORD_W)-1:0]    rd_addr,
    output logic [WORD_W-1:0]                   rd_data
`ifdef PRM_OBS_CNT_EN
    ,
    output logic [15:0]                         obs_cnt
`endif
);

    localparam int ADDR_W = $clog2(N_EDGE / WORD_W);

    prm_state_t state;
    logic       s1_valid;
    logic       s1_last;
    logic       xfer;
    logic       clr;

    assign xfer = obs_valid && obs_ready;
    assign clr  = start && ((state == IDLE) || (state == DONE));

    // Frame FSM with registered handshake/status outputs and stage-1 code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            obs_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            chk_code  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
`ifdef PRM_OBS_CNT_EN
            obs_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    s1_valid <= 1'b0;
                    if (start) begin
                        state     <= ACCUM;
                        obs_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef PRM_OBS_CNT_EN
                        obs_cnt   <= '0;
`endif
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        chk_code <= code_to_chk(obs_code);
                        s1_valid <= 1'b1;
                        s1_last  <= obs_last;
`ifdef PRM_OBS_CNT_EN
                        if (obs_cnt != 16'hFFFF) begin
                            obs_cnt <= obs_cnt + 16'd1;
                        end
`endif
                        if (obs_last) begin
                            state     <= DRAIN;
                            obs_ready <= 1'b0;
                        end
                    end else begin
                        s1_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last code's OR lands on this edge in the bitmap
                    s1_valid <= 1'b0;
                    if (s1_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    prm_mask_bitmap #(
        .N_EDGE (N_EDGE),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_bitmap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .merge   (s1_valid),
        .mask    (chk_mask),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Self-checking bench for prm_edge_mask_accum. Plays the checker bank with a
// simple model rule and predicts status/bitmap from frame-level events.
module tb_prm_edge_mask_accum;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          obs_valid = 1'b0;
    logic          obs_ready;
    logic [14:0]   obs_code = '0;
    logic          obs_last = 1'b0;
    logic [14:0]   chk_code;
    logic [1023:0] chk_mask;
    logic          busy;
    logic          done;
    logic [4:0]    rd_addr = '0;
    logic [31:0]   rd_data;
`ifdef PRM_OBS_CNT_EN
    logic [15:0]   obs_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Frame model: edge index of accepted start / last transfer, expected bitmap
    int            m_start = -1;
    int            m_last  = -1;
    logic [1023:0] exp_bm  = '0;
    int            exp_cnt = 0;
    logic [4:0]    prev_addr = '0;
    bit            e_rdy, e_busy, e_done;

    logic [14:0]   codes [100];

    prm_edge_mask_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .obs_valid (obs_valid),
        .obs_ready (obs_ready),
        .obs_code  (obs_code),
        .obs_last  (obs_last),
        .chk_code  (chk_code),
        .chk_mask  (chk_mask),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`ifdef PRM_OBS_CNT_EN
        ,
        .obs_cnt   (obs_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model checker: edge e is blocked when code bits (e mod 15) and ((e/64) mod 15) are both set
    function automatic logic [1023:0] model_mask(input logic [14:0] c);
        logic [1023:0] m;
        for (int e = 0; e < 1024; e++) begin
            m[e] = c[e % 15] & c[(e / 64) % 15];
        end
        return m;
    endfunction

    assign chk_mask = model_mask(chk_code);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_addr <= rd_addr;
    end

    // Per-cycle compare of status outputs, and of readout once the bitmap is final
    always @(negedge clk) begin
        if (rst_n) begin
            e_rdy  = (m_start >= 0) && (cyc >= m_start) && (m_last < 0 || cyc < m_last);
            e_busy = (m_start >= 0) && (m_last < 0 || cyc <= m_last);
            e_done = (m_start >= 0) && (m_last >= 0) && (cyc > m_last);
            check("obs_ready", 32'(obs_ready), 32'(e_rdy));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            if (e_done && cyc >= m_last + 2) begin
                check("rd_data_final", rd_data, exp_bm[prev_addr*32 +: 32]);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        m_start = cyc;
        m_last  = -1;
        exp_bm  = '0;
        exp_cnt = 0;
    endtask

    task automatic send(input logic [14:0] c, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            obs_valid = 1'b0;
            obs_code  = 15'($urandom);
            obs_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        obs_valid = 1'b1;
        obs_code  = c;
        obs_last  = last;
        @(posedge clk); #1;
        exp_bm = exp_bm | model_mask(c);
        exp_cnt++;
        if (last) m_last = cyc;
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        obs_code  = 15'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_all();
        for (int w = 0; w < 32; w++) begin
            rd_addr = 5'(w);
            @(posedge clk); #1;
            check("rd_word", rd_data, exp_bm[w*32 +: 32]);
        end
    endtask

    task automatic check_cnt();
`ifdef PRM_OBS_CNT_EN
        check("obs_cnt", 32'(obs_cnt), 32'(exp_cnt));
`endif
    endtask

    initial begin
        logic [1023:0] m;

        // Pin the model checker with hand-computed masks
        m = model_mask(15'h4000);
        check("pin_4000_w28", m[28*32 +: 32], 32'h0004_0008);
        check("pin_4000_w29", m[29*32 +: 32], 32'h8001_0002);
        check("pin_4000_w0", m[31:0], 32'h0000_0000);
        m = model_mask(15'h0000);
        check("pin_0000_w3", m[127:96], 32'h0000_0000);
        m = model_mask(15'h7FFF);
        check("pin_7fff_w3", m[127:96], 32'hFFFF_FFFF);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(obs_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chk_code", 32'(chk_code), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle: every word reads zero
        read_all();

        // Single-code frame with latency checks on word 28
        rd_addr = 5'd28;
        do_start();
        send(15'h4000, 1'b1, 0);
        check("lat_edge0", rd_data, 32'h0);
        @(posedge clk); #1;
        check("lat_edge1", rd_data, 32'h0);
        check("done_rise", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("lat_edge2", rd_data, 32'h0004_0008);
        read_all();
        check_cnt();

        // Streaming frame, same codes under two different gap patterns
        foreach (codes[i]) codes[i] = 15'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            do_start();
            for (int i = 0; i < 100; i++) begin
                send(codes[i], i == 99, (pass == 0) ? 0 : int'($urandom_range(0, 2)));
            end
            wait_done();
            read_all();
            check_cnt();
        end

        // Re-frame: all-blocked frame, then simultaneous start+read, then code 0
        do_start();
        send(15'h7FFF, 1'b1, 0);
        wait_done();
        rd_addr = 5'd3;
        @(posedge clk); #1;
        check("w3_full", rd_data, 32'hFFFF_FFFF);
        do_start();
        check("preclear_read", rd_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("postclear_read", rd_data, 32'h0);
        send(15'h0000, 1'b1, 0);
        wait_done();
        @(posedge clk); #1;
        check("w3_cleared", rd_data, 32'h0);
        read_all();

        // start pulsed during ACCUM is ignored
        do_start();
        send(15'h0123, 1'b0, 0);
        start = 1'b1;
        send(15'h4A50, 1'b0, 0);
        start = 1'b0;
        send(15'h1F00, 1'b1, 1);
        wait_done();
        read_all();
        check_cnt();

        // Asynchronous reset mid-frame
        do_start();
        for (int i = 0; i < 10; i++) send(15'($urandom), 1'b0, 0);
        m_start = -1;
        m_last  = -1;
        exp_bm  = '0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        #1;
        check("mid_rst_ready", 32'(obs_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_chk_code", 32'(chk_code), 32'd0);
        check("mid_rst_rd_data", rd_data, 32'd0);
        check_cnt();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start();
        send(15'h4001, 1'b1, 0);
        wait_done();
        read_all();
        check_cnt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
